// File: rtl/regfile_pkg.sv
// Shared types and constants for the architectural register file.
// Default geometry: 32 registers of 64 bits, register 31 reads as zero (XZR).
package regfile_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_ADDR_W   = 5;

  // Index of the hardwired zero register; it has no storage behind it.
  localparam int ZERO_REG = DEF_NUM_REGS - 1;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] reg_word_t;

endpackage

// File: rtl/reg_file_reg_en.sv
// reg_en: one storage word with synchronous load enable and
// asynchronous active-high clear to zero.
module reg_en #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset wins over any load, so writes while reset is high are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file.sv
// reg_file: architectural register file, one write port and two
// combinational read ports. The highest index is the zero register.
// Optional macro REGFILE_BYPASS_EN: forwards the in-flight write data to a
// read port addressing the register being written in the same cycle.
module reg_file
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(NUM_REGS - 1);

  logic [NUM_REGS-1:0] wr_en;
  logic [DATA_W-1:0]   reg_q [NUM_REGS];

  // One-hot write enable; the zero register never gets an enable.
  always_comb begin
    wr_en = '0;
    if (reg_write && (write_reg != ZERO_IDX)) begin
      wr_en[write_reg] = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS - 1; gi++) begin : g_regs
      reg_en #(.W(DATA_W)) u_reg (
        .clk   (clk),
        .reset (reset),
        .en    (wr_en[gi]),
        .d     (write_data),
        .q     (reg_q[gi])
      );
    end
  endgenerate

  // The top slot is a constant so the read mux never indexes past storage.
  assign reg_q[NUM_REGS-1] = '0;

  // Read port 1: stored word, optional same-cycle forward, zero register forced to 0.
  always_comb begin
    read_data1 = reg_q[read_reg1];
`ifdef REGFILE_BYPASS_EN
    if (reg_write && !reset && (write_reg == read_reg1)) begin
      read_data1 = write_data;
    end
`endif
    if (read_reg1 == ZERO_IDX) begin
      read_data1 = '0;
    end
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    read_data2 = reg_q[read_reg2];
`ifdef REGFILE_BYPASS_EN
    if (reg_write && !reset && (write_reg == read_reg2)) begin
      read_data2 = write_data;
    end
`endif
    if (read_reg2 == ZERO_IDX) begin
      read_data2 = '0;
    end
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file for the single-cycle CPU.
- Writeback stage writes one register per clock; decode and operand fetch read two registers combinationally.
- Register 31 is the hardwired zero register (XZR).
- All state resets asynchronously to zero.

Parameters:
- NUM_REGS, 32, number of architectural registers; must be a power of 2.
- DATA_W, 64, register width in bits.
- ADDR_W, 5, register index width; must equal log2(NUM_REGS).

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-high; clears every register to 0 immediately, independent of clk.
- reg_write  input  1  write enable; sampled on rising clk.
- write_reg  input  ADDR_W  destination register index.
- write_data  input  DATA_W  value to store.
- read_reg1  input  ADDR_W  index for read port 1.
- read_reg2  input  ADDR_W  index for read port 2.
- read_data1  output  DATA_W  contents of read_reg1; combinational.
- read_data2  output  DATA_W  contents of read_reg2; combinational.

Behaviour:
- Storage: NUM_REGS-1 writable DATA_W-bit registers, indices 0..NUM_REGS-2. Index NUM_REGS-1 has no storage.
- Reset: asserting reset sets all stored registers to 0 asynchronously.
  - Both read outputs reflect 0 within the same delta/combinational settle; no clock edge needed.
  - While reset is high, writes are ignored.
  - Reset deassertion coincident with a rising clk: that edge performs no write.
- Write: on rising clk with reset low and reg_write=1, reg[write_reg] <= write_data.
  - New value is visible on the read ports after that edge.
  - Write latency is 1 cycle.
- Write with reg_write=0: no register changes.
- Write to index NUM_REGS-1: silently discarded. No storage changes and no other register is touched.
- Read: read_dataN = (read_regN == NUM_REGS-1) ? 0 : reg[read_regN]. Purely combinational, zero-cycle latency.
- Both ports may address the same register; each returns identical data.
- Same-cycle read/write of the same index (macro undefined): the read returns the old value until the edge, then the new value.
- Write-enable decode is one-hot. Exactly one register is enabled per write, or none for index NUM_REGS-1 or reg_write=0.
- No X propagation: read outputs are always defined after reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Each read port has a write-to-read bypass.
  - If reg_write=1, reset=0, write_reg==read_regN and read_regN != NUM_REGS-1, then read_dataN = write_data combinationally in the same cycle.
  - The zero register still reads 0 with bypass active.
  - Intended for the pipelined variant to remove one forwarding path.
- Undefined: reads return stored contents only, as above.

Decomposition:
- Package regfile_pkg:
  - localparam ZERO_REG = NUM_REGS-1 (31).
  - typedef logic [ADDR_W-1:0] reg_idx_t.
  - typedef logic [DATA_W-1:0] reg_word_t.
- Sub-module reg_en: DATA_W-wide register with synchronous load enable and asynchronous active-high reset to 0, ports clk, reset, en, d, q.
  - Instantiated NUM_REGS-1 times via generate.
- Write-enable decoder and read muxes are inline in reg_file.

Test Plan:
- Assert reset mid-cycle after writing X3=64'hDEAD_BEEF -> read_data1 (read_reg1=3) drops to 0 before next clk edge; a write attempted while reset is high leaves X3=0.
- Write Xi=i*64'h0101_0101_0101_0101 for i=0..30 on consecutive edges, then read all pairs (i, 30-i) -> both ports return the written values; read of index 31 returns 0.
- reg_write=1, write_reg=31, write_data=64'hFFFF_FFFF_FFFF_FFFF -> read of 31 returns 0; X0..X30 unchanged from previous scenario.
- reg_write=0, write_reg=5, write_data=64'h1234 across 3 edges -> X5 retains its prior value.
- Same cycle: write X7=64'hA5A5, read_reg1=read_reg2=7, prior X7=64'h1111 -> without REGFILE_BYPASS_EN, 64'h1111 before the edge and 64'hA5A5 after; with the macro, 64'hA5A5 immediately.
- Random regression of 2000 cycles of random reg_write/indices/data with random async reset pulses, checked against a scoreboard array model -> zero mismatches.
